serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing diff = a − b − bin, one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a registered borrow. It sits directly downstream of the existing `full_subtractor` cell and wraps it into a multi-cycle arithmetic stage with a start/busy/done handshake. It is used where area matters more than latency.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 98 +++++++++
 tb/tb_serial_subtractor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_sub_pkg;

    localparam int SERIAL_SUB_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full-subtractor cell: d = a - b - bin, bout is the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, one bit per clock.
// Optional signed overflow flag on port ovf when SERIAL_SUB_OVF_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for start, result registers hold last operation
// ST_SHIFT | one operand bit pair consumed per clock through the cell
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic               brw;
    logic [CNT_W-1:0]   cnt;
    logic               cell_d;
    logic               cell_bout;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SHIFT;
                        busy  <= 1'b1;
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        diff  <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    brw  <= cell_bout;
                    diff <= {cell_d, diff[WIDTH-1:1]};
                    if (cnt == LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bout  <= cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                        // brw here is the borrow into the MSB stage
                        ovf   <= brw ^ cell_bout;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) with a result scoreboard.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        exp_t e;
        logic [W:0] full;
        int sd;
        full   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        e.diff = full[W-1:0];
        e.bout = full[W];
        sd     = $signed(ma) - $signed(mb) - int'(mbin);
        e.ovf  = (sd > 127) || (sd < -128);
        return e;
    endfunction

    task automatic push(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        exp_q.push_back(model(ma, mb, mbin));
    endtask

    // Waits (bounded) for done, counting busy cycles on the way, then scores the result.
    task automatic wait_done(input string tag, output int busy_cnt);
        exp_t e;
        bit seen;
        busy_cnt = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_diff"}, 32'(diff), 32'(e.diff));
            check({tag, "_bout"}, 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
            check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ma, input logic [W-1:0] mb,
                          input logic mbin);
        int bc;
        a = ma; b = mb; bin = mbin; start = 1'b1;
        push(ma, mb, mbin);
        @(negedge clk);
        start = 1'b0;
        a = ~ma; b = ~mb;
        wait_done(tag, bc);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd8);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int bc;
        int t_prev;
        bit extra;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        run_op("basic", 8'h5A, 8'h23, 1'b0);
        run_op("under", 8'h00, 8'h01, 1'b0);
        run_op("eq_bin", 8'h10, 8'h10, 1'b1);

        // Reset mid-operation: bout is still 1 from the previous result.
        a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
        push(8'h5A, 8'h23, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_bout", 32'(bout), 32'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) extra = 1;
        end
        check("midrst_no_done", 32'(extra), 32'd0);
        run_op("after_rst", 8'h37, 8'h40, 1'b0);

        run_op("ovf_neg", 8'h80, 8'h01, 1'b0);
        run_op("ovf_none", 8'h05, 8'h03, 1'b0);

        // start during busy is ignored
        a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
        push(8'h5A, 8'h23, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", bc);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) extra = 1;
        end
        check("ignore_single_done", 32'(extra), 32'd0);

        // start held high: one result every WIDTH+1 clocks
        a = 8'h09; b = 8'h04; bin = 1'b0; start = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            push(8'h09, 8'h04, 1'b0);
            @(negedge clk);
            wait_done($sformatf("held%0d", k), bc);
            if (k > 0) check($sformatf("held%0d_period", k), 32'(cyc - t_prev), 32'd9);
            t_prev = cyc;
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        // start present in the first cycle after reset release
        rst_n = 1'b0;
        @(negedge clk);
        a = 8'h01; b = 8'h02; bin = 1'b1; start = 1'b1;
        rst_n = 1'b1;
        push(8'h01, 8'h02, 1'b1);
        @(negedge clk);
        start = 1'b0;
        check("post_rel_busy", 32'(busy), 32'd1);
        wait_done("post_rel", bc);
        check("post_rel_busy_cycles", 32'(bc), 32'd8);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
